mem_arbiter: RTL and testbench

Shares one single-port memory bus between the instruction fetch path and the execute stage's load/store path. Holds a granted transaction on the bus until the memory acknowledges it or a timeout expires, then returns the result to the owning requester. Sits between the fetch unit, `ex`, and the memory model. Turns the current ideal single-cycle memory access into a handshaked, multi-cycle one.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// Holds data width, arbiter state encodings and owner codes.
package mem_arbiter_pkg;

  localparam int unsigned XLEN_WIDTH = 32;

  localparam logic ARB_TRUE  = 1'b1;
  localparam logic ARB_FALSE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

  // Winner of a contended cycle is whoever did not own the bus last;
  // an uncontended request simply wins.
  function automatic arb_owner_e arb_pick(
    input logic       if_req,
    input logic       d_req,
    input arb_owner_e last
  );
    arb_owner_e w;
    w = ARB_OWNER_I;
    if (if_req && d_req) begin
      w = (last == ARB_OWNER_I) ? ARB_OWNER_D : ARB_OWNER_I;
    end else if (d_req) begin
      w = ARB_OWNER_D;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store.
// Ports: clk/rst; if_* fetch side; d_* data side; bus_* memory side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [XLEN_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic                  if_err,
  output logic [XLEN_WIDTH-1:0] if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [XLEN_WIDTH-1:0] d_addr,
  input  logic [XLEN_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic                  d_err,
  output logic [XLEN_WIDTH-1:0] d_rdata,

  output logic                  bus_req,
  output logic                  bus_we,
  output logic [XLEN_WIDTH-1:0] bus_addr,
  output logic [XLEN_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [XLEN_WIDTH-1:0] bus_rdata
);

  // Timer value seen in the last BUSY cycle before abort.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e            state_q;
  arb_owner_e            last_q;
  logic [7:0]            timer_q;

  logic                  if_gnt_q;
  logic                  if_rvalid_q;
  logic                  if_err_q;
  logic [XLEN_WIDTH-1:0] if_rdata_q;
  logic                  d_gnt_q;
  logic                  d_rvalid_q;
  logic                  d_err_q;
  logic [XLEN_WIDTH-1:0] d_rdata_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [XLEN_WIDTH-1:0] bus_addr_q;
  logic [XLEN_WIDTH-1:0] bus_wdata_q;

  logic                  any_req;
  arb_owner_e            pick;
  logic                  take_i;
  logic                  take_d;
  logic                  tmo_hit;
  logic                  own_d;
  logic [XLEN_WIDTH-1:0] rd_val;

  always_comb begin
    any_req = if_req | d_req;
    pick    = arb_pick(if_req, d_req, last_q);
    take_i  = 1'b0;
    take_d  = 1'b0;
    if (state_q == ARB_IDLE && any_req) begin
      take_i = (pick == ARB_OWNER_I);
      take_d = (pick == ARB_OWNER_D);
    end
  end

  always_comb begin
    tmo_hit = (timer_q == TMO_LAST);
    own_d   = (state_q == ARB_BUSY_D);
    // Stores complete with zero read data.
    rd_val  = bus_we_q ? '0 : bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= ARB_OWNER_I;
      timer_q     <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;

      unique case (state_q)
        ARB_IDLE: begin
          timer_q <= '0;
          if (take_d) begin
            state_q     <= ARB_BUSY_D;
            last_q      <= ARB_OWNER_D;
            d_gnt_q     <= 1'b1;
            bus_req_q   <= 1'b1;
            bus_we_q    <= d_we;
            bus_addr_q  <= d_addr;
            bus_wdata_q <= d_wdata;
          end else if (take_i) begin
            state_q     <= ARB_BUSY_I;
            last_q      <= ARB_OWNER_I;
            if_gnt_q    <= 1'b1;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end
        end

        ARB_BUSY_I, ARB_BUSY_D: begin
          // Ack beats a timeout landing in the same cycle.
          if (bus_ack) begin
            if (own_d) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= rd_val;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= rd_val;
            end
            state_q     <= ARB_IDLE;
            timer_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end else if (tmo_hit) begin
            if (own_d) begin
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              if_err_q   <= 1'b1;
              if_rdata_q <= '0;
            end
            state_q     <= ARB_IDLE;
            timer_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end

        default: begin
          state_q   <= ARB_IDLE;
          timer_q   <= '0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_err(d_err), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
  } outs_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    check_en = 0;
  bit    done     = 0;
  outs_t cur_exp, exp_next;

  // Model: one outstanding transaction, described by who owns it,
  // its latched fields and the cycle its grant appeared.
  bit          m_busy, m_owner, m_last, m_we;
  int          m_start;
  logic [31:0] m_addr, m_wdata, m_rd_i, m_rd_d;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h",
               name, cyc, act, exp);
    end
  endfunction

  function automatic void model_step();
    outs_t n;
    logic [31:0] v;
    bit o;
    n = '0;
    n.if_rdata = m_rd_i;
    n.d_rdata  = m_rd_d;
    if (rst) begin
      m_busy = 0; m_last = 0; m_rd_i = '0; m_rd_d = '0;
      n = '0;
    end else if (m_busy) begin
      if (bus_ack) begin
        v = m_we ? 32'h0 : bus_rdata;
        if (m_owner) begin
          n.d_rvalid = 1; m_rd_d = v; n.d_rdata = v;
        end else begin
          n.if_rvalid = 1; m_rd_i = v; n.if_rdata = v;
        end
        m_busy = 0;
      end else if (cyc == m_start + TO - 1) begin
        if (m_owner) begin
          n.d_err = 1; m_rd_d = '0; n.d_rdata = '0;
        end else begin
          n.if_err = 1; m_rd_i = '0; n.if_rdata = '0;
        end
        m_busy = 0;
      end else begin
        n.bus_req = 1; n.bus_we = m_we;
        n.bus_addr = m_addr; n.bus_wdata = m_wdata;
      end
    end else if (if_req || d_req) begin
      if (if_req && d_req) o = !m_last;
      else o = d_req;
      m_busy = 1; m_owner = o; m_last = o; m_start = cyc + 1;
      m_we    = o ? d_we : 1'b0;
      m_addr  = o ? d_addr : if_addr;
      m_wdata = o ? d_wdata : 32'h0;
      if (o) n.d_gnt = 1; else n.if_gnt = 1;
      n.bus_req = 1; n.bus_we = m_we;
      n.bus_addr = m_addr; n.bus_wdata = m_wdata;
    end
    exp_next = n;
  endfunction

  task automatic clk_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    cur_exp = exp_next;
  endtask

  function automatic void cmp_all();
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, cur_exp.if_gnt});
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, cur_exp.if_rvalid});
    chk("if_err", {31'b0, if_err}, {31'b0, cur_exp.if_err});
    chk("if_rdata", if_rdata, cur_exp.if_rdata);
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, cur_exp.d_gnt});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, cur_exp.d_rvalid});
    chk("d_err", {31'b0, d_err}, {31'b0, cur_exp.d_err});
    chk("d_rdata", d_rdata, cur_exp.d_rdata);
    chk("bus_req", {31'b0, bus_req}, {31'b0, cur_exp.bus_req});
    if (cur_exp.bus_req) begin
      chk("bus_we", {31'b0, bus_we}, {31'b0, cur_exp.bus_we});
      chk("bus_addr", bus_addr, cur_exp.bus_addr);
      chk("bus_wdata", bus_wdata, cur_exp.bus_wdata);
    end
    chk("onehot_done",
        32'($countones({if_rvalid, if_err, d_rvalid, d_err}) <= 1), 32'd1);
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'($countones({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid,
                          d_err, bus_req, bus_we})) |
           if_rdata | d_rdata | bus_addr | bus_wdata;
  endfunction

  task automatic wait_gnt(output int w);
    w = 0;
    do begin
      clk_cycle();
      w++;
    end while (!(if_gnt || d_gnt) && w < 8);
  endtask

  initial begin
    int w, bq;
    bit seq [4];
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; bus_ack = 0; bus_rdata = 0;
    m_busy = 0; m_owner = 0; m_last = 0; m_we = 0; m_start = 0;
    m_addr = 0; m_wdata = 0; m_rd_i = 0; m_rd_d = 0;
    cur_exp = '0; exp_next = '0;
    clk_cycle();
    check_en = 1;

    fork
      begin : compare
        while (!done) begin
          @(negedge clk);
          if (check_en && !done) cmp_all();
        end
      end

      begin : stim
        // Reset state
        chk("reset_outs", all_outs(), 32'h0);
        rst = 0;

        // Fetch only, ack two cycles after bus_req
        if_req = 1; if_addr = 32'h100;
        clk_cycle();
        chk("f_gnt", {31'b0, if_gnt}, 32'd1);
        chk("f_bus_addr", bus_addr, 32'h100);
        chk("f_bus_we", {31'b0, bus_we}, 32'd0);
        if_req = 0;
        clk_cycle();
        clk_cycle();
        bus_ack = 1; bus_rdata = 32'h00000013;
        clk_cycle();
        bus_ack = 0;
        chk("f_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("f_rdata", if_rdata, 32'h13);

        // Contention from reset: D, I, D, I
        rst = 1;
        clk_cycle();
        rst = 0;
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        seq[0] = 1; seq[1] = 0; seq[2] = 1; seq[3] = 0;
        for (int k = 0; k < 4; k++) begin
          wait_gnt(w);
          chk("ct_lat", w, 1);
          chk("ct_owner", {31'b0, d_gnt}, {31'b0, seq[k]});
          if (k == 0) begin
            chk("ct_we", {31'b0, bus_we}, 32'd1);
            chk("ct_addr", bus_addr, 32'h2000);
            chk("ct_wdata", bus_wdata, 32'hDEADBEEF);
          end
          bus_ack = 1; bus_rdata = 32'h5555AAAA;
          clk_cycle();
          bus_ack = 0;
          if (seq[k]) begin
            chk("ct_drvalid", {31'b0, d_rvalid}, 32'd1);
            chk("ct_drdata", d_rdata, 32'h0);
          end else begin
            chk("ct_irvalid", {31'b0, if_rvalid}, 32'd1);
          end
        end
        if_req = 0; d_req = 0;

        // Load to give d_rdata a known nonzero value
        d_req = 1; d_we = 0; d_addr = 32'h3000;
        clk_cycle();
        d_req = 0;
        bus_ack = 1; bus_rdata = 32'hCAFE0001;
        clk_cycle();
        bus_ack = 0;
        chk("ld_rdata", d_rdata, 32'hCAFE0001);

        // Timeout: no ack
        d_req = 1; d_addr = 32'h3004;
        clk_cycle();
        chk("to_gnt", {31'b0, d_gnt}, 32'd1);
        d_req = 0;
        bq = 0; w = 0;
        while (!d_err && w < 20) begin
          if (bus_req) bq++;
          clk_cycle();
          w++;
        end
        chk("to_busreq_len", bq, TO);
        chk("to_err_at", w, TO);
        chk("to_err", {31'b0, d_err}, 32'd1);
        chk("to_rdata", d_rdata, 32'h0);
        if_req = 1; if_addr = 32'h104;
        clk_cycle();
        chk("to_next_gnt", {31'b0, if_gnt}, 32'd1);
        if_req = 0;
        bus_ack = 1; bus_rdata = 32'h00100093;
        clk_cycle();
        bus_ack = 0;
        chk("to_next_rdata", if_rdata, 32'h00100093);

        // Ack on the timeout cycle
        d_req = 1; d_addr = 32'h3008;
        clk_cycle();
        d_req = 0;
        for (int k = 0; k < TO - 1; k++) clk_cycle();
        chk("at_busreq", {31'b0, bus_req}, 32'd1);
        bus_ack = 1; bus_rdata = 32'h00000077;
        clk_cycle();
        bus_ack = 0;
        chk("at_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("at_err", {31'b0, d_err}, 32'd0);
        chk("at_rdata", d_rdata, 32'h77);

        // Reset during BUSY_D, stray ack afterwards
        d_req = 1; d_addr = 32'h300C;
        clk_cycle();
        chk("rs_gnt", {31'b0, d_gnt}, 32'd1);
        d_req = 0; rst = 1;
        clk_cycle();
        rst = 0;
        chk("rs_outs", all_outs(), 32'h0);
        bus_ack = 1; bus_rdata = 32'h12345678;
        clk_cycle();
        bus_ack = 0;
        chk("rs_stray", all_outs(), 32'h0);

        // Ack in IDLE with no requests
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        clk_cycle();
        bus_ack = 0;
        clk_cycle();
        chk("idle_ack", all_outs(), 32'h0);

        // last_owner back to I after reset: data wins
        if_req = 1; d_req = 1; d_we = 0;
        wait_gnt(w);
        chk("rs_owner", {31'b0, d_gnt}, 32'd1);
        if_req = 0; d_req = 0;
        bus_ack = 1; bus_rdata = 32'h0BADF00D;
        clk_cycle();
        bus_ack = 0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
          if (cur_exp.if_gnt) if_req = 0;
          if (cur_exp.d_gnt) d_req = 0;
          if (if_req && $urandom_range(99) < 3) if_req = 0;
          if (d_req && $urandom_range(99) < 3) d_req = 0;
          if (!if_req && $urandom_range(99) < 30) begin
            if_req = 1; if_addr = $urandom;
          end
          if (!d_req && $urandom_range(99) < 30) begin
            d_req = 1; d_we = 1'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
          end
          bus_rdata = $urandom;
          if (cur_exp.bus_req) bus_ack = ($urandom_range(99) < 35);
          else bus_ack = ($urandom_range(99) < 5);
          rst = ($urandom_range(199) == 0);
          clk_cycle();
        end
        rst = 0; bus_ack = 0; if_req = 0; d_req = 0;
        clk_cycle();
        done = 1;
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
